// File: rtl/button_conditioner.sv
// button_conditioner
// Per-channel push-button conditioning: two-flop synchronisers on the raw
// button and mode inputs, a counter-based debouncer producing a clean level
// plus press/release strobes, and an LED driver that either follows the
// debounced level or shows a toggle register advanced on every press.

module button_conditioner #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] mode,
    output logic [N_CH-1:0] led_out,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse
);

    // Terminal count: the last value the counter may hold before a change is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0]  btn_meta;
    logic [N_CH-1:0]  btn_sync;
    logic [N_CH-1:0]  mode_meta;
    logic [N_CH-1:0]  mode_sync;
    logic [CNT_W-1:0] cnt [N_CH];
    logic [N_CH-1:0]  toggle_q;
    logic [N_CH-1:0]  differ;
    logic [N_CH-1:0]  accept;

    // Two-flop synchronisers; only the second stage is consumed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every flop sampling the pre-edge
        // value, which is what makes btn_meta -> btn_sync a real two-stage chain.
        if (!rst_n) begin
            btn_meta  <= '0;
            btn_sync  <= '0;
            mode_meta <= '0;
            mode_sync <= '0;
        end else begin
            btn_meta  <= btn_in;
            btn_sync  <= btn_meta;
            mode_meta <= mode;
            mode_sync <= mode_meta;
        end
    end

    // A change is accepted when the input still differs on the terminal count.
    always_comb begin
        // NOTE: every bit gets a default before the loop, so no latch is inferred.
        accept = '0;
        differ = btn_sync ^ btn_level;
        for (int c = 0; c < N_CH; c++) begin
            accept[c] = differ[c] && (cnt[c] == CNT_LAST);
        end
    end

    // Debounce counters, accepted level and one-cycle transition strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counter array is explicitly cleared; a reset abort must
            // discard any partial count so no stale transition can complete.
            for (int c = 0; c < N_CH; c++) begin
                cnt[c] <= '0;
            end
            btn_level     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (!differ[c] || accept[c]) begin
                    cnt[c] <= '0;
                end else begin
                    cnt[c] <= cnt[c] + CNT_W'(1);
                end
            end
            btn_level     <= btn_level ^ accept;
            press_pulse   <= accept & btn_sync;
            release_pulse <= accept & ~btn_sync;
        end
    end

    // Toggle register flips once per press strobe, independent of mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_q ^ press_pulse;
        end
    end

    // Registered LED drive: toggle register in toggle mode, debounced level otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out <= '0;
        end else begin
            led_out <= (mode_sync & toggle_q) | (~mode_sync & btn_level);
        end
    end

endmodule
